// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op-codes (also used by the controller decoder) and FSM states.
package mdu_pkg;

   typedef enum logic [3:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MFHI  = 4'd5,
      MDU_MFLO  = 4'd6,
      MDU_MTHI  = 4'd7,
      MDU_MTLO  = 4'd8
   } mdu_op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } mdu_state_e;

   // Multi-cycle ops; div/divu only count when the divider is built in.
   function automatic logic is_long_op(input logic [3:0] op, input logic div_en);
      return (op == MDU_MULT) || (op == MDU_MULTU) ||
             (div_en && ((op == MDU_DIV) || (op == MDU_DIVU)));
   endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage request / result bundle between the pipeline and the MDU.
interface mdu_if;
   logic        req;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        d_is_mdu;
   logic        start;
   logic        busy;
   logic        stall;
   logic [31:0] rd_data;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output req, op, a, b, d_is_mdu,
      input  start, busy, stall, rd_data, hi, lo
   );

   modport slave (
      input  req, op, a, b, d_is_mdu,
      output start, busy, stall, rd_data, hi, lo
   );
endinterface

// File: rtl/mdu_div_core.sv
// 32-bit signed/unsigned divider: quotient truncates toward zero, remainder
// follows the dividend's sign. Divide-by-zero yields 0/0 (caller discards it).
module mdu_div_core (
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        is_signed,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic        neg_a, neg_b;
   logic [31:0] mag_a, mag_b, q_mag, r_mag;

   // Divide magnitudes, then restore signs; -2^31 maps onto itself as unsigned.
   always_comb begin
      neg_a = is_signed & dividend[31];
      neg_b = is_signed & divisor[31];
      mag_a = neg_a ? (~dividend + 32'd1) : dividend;
      mag_b = neg_b ? (~divisor + 32'd1) : divisor;
      q_mag = 32'd0;
      r_mag = 32'd0;
      if (mag_b != 32'd0) begin
         q_mag = mag_a / mag_b;
         r_mag = mag_a % mag_b;
      end
      quotient  = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
      remainder = neg_a ? (~r_mag + 32'd1) : r_mag;
   end

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit with architectural HI/LO and a fixed-latency busy window.
// Define MDU_DIV_EN to build div/divu; otherwise ops 3/4 behave as none.
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic reset,
   mdu_if.slave bus
);

`ifdef MDU_DIV_EN
   localparam logic DIV_EN = 1'b1;
`else
   localparam logic DIV_EN = 1'b0;
`endif

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   mdu_state_e  state, state_nxt;
   logic [CW-1:0] cnt;
   logic [3:0]  op_q;
   logic [31:0] a_q, b_q;
   logic [31:0] hi_q, lo_q;
   logic        busy, commit, start, wr_hi, wr_lo, last;

   logic               mul_sx;
   logic signed [32:0] mul_a, mul_b;
   logic signed [65:0] mul_full;
   logic [63:0]        product;

   assign last  = (cnt == CW'(1));
   assign start = bus.req & is_long_op(bus.op, DIV_EN) & ~busy;
   assign wr_hi = bus.req & (bus.op == MDU_MTHI) & ~busy;
   assign wr_lo = bus.req & (bus.op == MDU_MTLO) & ~busy;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_BUSY;
         S_BUSY:  if (last)  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM: outputs; commit lands on the BUSY->IDLE edge
   always_comb begin
      busy   = (state == S_BUSY);
      commit = (state == S_BUSY) && last;
   end

   // Operands are latched so forwarding changes after issue cannot disturb the op.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt  <= '0;
         op_q <= MDU_NONE;
         a_q  <= 32'd0;
         b_q  <= 32'd0;
      end else if (start) begin
         cnt  <= ((bus.op == MDU_MULT) || (bus.op == MDU_MULTU)) ? CW'(MULT_CYCLES)
                                                                 : CW'(DIV_CYCLES);
         op_q <= bus.op;
         a_q  <= bus.a;
         b_q  <= bus.b;
      end else if (busy) begin
         cnt  <= cnt - CW'(1);
      end
   end

   // 33x33 signed multiply covers both mult (sign-extend) and multu (zero-extend).
   always_comb begin
      mul_sx   = (op_q == MDU_MULT);
      mul_a    = $signed({mul_sx & a_q[31], a_q});
      mul_b    = $signed({mul_sx & b_q[31], b_q});
      mul_full = mul_a * mul_b;
      product  = mul_full[63:0];
   end

`ifdef MDU_DIV_EN
   logic [31:0] div_q, div_r;

   mdu_div_core u_div (
      .dividend  (a_q),
      .divisor   (b_q),
      .is_signed (op_q == MDU_DIV),
      .quotient  (div_q),
      .remainder (div_r)
   );
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q <= 32'd0;
         lo_q <= 32'd0;
      end else if (commit) begin
         case (op_q)
            MDU_MULT, MDU_MULTU: begin
               hi_q <= product[63:32];
               lo_q <= product[31:0];
            end
`ifdef MDU_DIV_EN
            MDU_DIV, MDU_DIVU: begin
               if (b_q != 32'd0) begin
                  hi_q <= div_r;
                  lo_q <= div_q;
               end
            end
`endif
            default: ;
         endcase
      end else begin
         if (wr_hi) hi_q <= bus.a;
         if (wr_lo) lo_q <= bus.a;
      end
   end

   always_comb begin
      bus.rd_data = 32'd0;
      if (bus.req) begin
         case (bus.op)
            MDU_MFHI: bus.rd_data = hi_q;
            MDU_MFLO: bus.rd_data = lo_q;
            default:  bus.rd_data = 32'd0;
         endcase
      end
   end

   assign bus.start = start;
   assign bus.busy  = busy;
   assign bus.stall = bus.d_is_mdu & (busy | start);
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: expected HI/LO queued at issue, checked when busy drops.
module tb_mdu_unit;
   import mdu_pkg::*;

`ifdef MDU_DIV_EN
   localparam logic DIV_EN = 1'b1;
`else
   localparam logic DIV_EN = 1'b0;
`endif
   localparam int MC = 5;
   localparam int DC = 10;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   logic [63:0] sb_q[$];

   mdu_if bus();

   mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] h,
                                         input logic [31:0] l);
      logic signed [63:0] sp;
      logic signed [31:0] sq, sr;
      model = {h, l};
      case (op)
         MDU_MULT: begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            model = sp;
         end
         MDU_MULTU: model = {32'd0, a} * {32'd0, b};
         MDU_DIV: if (DIV_EN && b != 32'd0) begin
            sq = $signed(a) / $signed(b);
            sr = $signed(a) % $signed(b);
            model = {sr, sq};
         end
         MDU_DIVU: if (DIV_EN && b != 32'd0) model = {a % b, a / b};
         default: ;
      endcase
   endfunction

   // Issues one op in the current cycle and follows it until busy drops.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic dmdu);
      logic [31:0] pre_hi, pre_lo;
      logic [63:0] e;
      logic        long_op;
      int          exp_n, n, early, bad_stall;
      pre_hi  = bus.hi;
      pre_lo  = bus.lo;
      long_op = (op == MDU_MULT) || (op == MDU_MULTU) ||
                (DIV_EN && ((op == MDU_DIV) || (op == MDU_DIVU)));
      exp_n   = !long_op ? 0 : ((op == MDU_MULT) || (op == MDU_MULTU)) ? MC : DC;
      bus.req = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.d_is_mdu = dmdu;
      #1;
      chk({tag, "_start"}, 64'(bus.start), 64'(long_op));
      chk({tag, "_stall_T"}, 64'(bus.stall), 64'(dmdu & long_op));
      sb_q.push_back(model(op, a, b, pre_hi, pre_lo));
      tick();
      bus.req = 1'b0; bus.op = MDU_NONE;
      #1;
      n = 0; early = 0; bad_stall = 0;
      while (bus.busy && n < 200) begin
         n++;
         if (bus.stall !== dmdu) bad_stall++;
         if (bus.hi !== pre_hi || bus.lo !== pre_lo) early++;
         tick();
         #1;
      end
      chk({tag, "_busy_cycles"}, 64'(n), 64'(exp_n));
      chk({tag, "_early_commit"}, 64'(early), 64'd0);
      chk({tag, "_stall_busy"}, 64'(bad_stall), 64'd0);
      chk({tag, "_stall_after"}, 64'(bus.stall), 64'd0);
      e = sb_q.pop_front();
      chk({tag, "_hi"}, 64'(bus.hi), 64'(e[63:32]));
      chk({tag, "_lo"}, 64'(bus.lo), 64'(e[31:0]));
   endtask

   initial begin
      logic [31:0] pre_hi, pre_lo;
      int          w;
      bus.req = 1'b0; bus.op = MDU_NONE; bus.a = 32'd0; bus.b = 32'd0; bus.d_is_mdu = 1'b0;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_hi", 64'(bus.hi), 64'd0);
      chk("rst_lo", 64'(bus.lo), 64'd0);
      chk("rst_start", 64'(bus.start), 64'd0);

      run_op("mult", MDU_MULT, 32'hFFFFFFFD, 32'd7, 1'b1);
      chk("mult_hi_const", 64'(bus.hi), 64'hFFFFFFFF);
      chk("mult_lo_const", 64'(bus.lo), 64'hFFFFFFEB);
      run_op("multu", MDU_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
      chk("multu_hi_const", 64'(bus.hi), 64'd1);
      chk("multu_lo_const", 64'(bus.lo), 64'hFFFFFFFE);
      run_op("mult_min", MDU_MULT, 32'h80000000, 32'h80000000, 1'b0);
      run_op("mult_mix", MDU_MULT, 32'd12345, 32'hFFFFFD5A, 1'b1);
      run_op("multu_big", MDU_MULTU, 32'h89ABCDEF, 32'hFEDCBA98, 1'b0);

      run_op("div", MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
`ifdef MDU_DIV_EN
      chk("div_lo_const", 64'(bus.lo), 64'hFFFFFFFD);
      chk("div_hi_const", 64'(bus.hi), 64'hFFFFFFFF);
`endif
      run_op("div0", MDU_DIV, 32'd55, 32'd0, 1'b1);
      run_op("div_negb", MDU_DIV, 32'd7, 32'hFFFFFFFE, 1'b0);
      run_op("divu", MDU_DIVU, 32'hFFFFFFF9, 32'd2, 1'b0);
      run_op("divu0", MDU_DIVU, 32'd9, 32'd0, 1'b0);

      // mthi / start / mflo attempted while a mult is in flight
      run_op("mult_setup", MDU_MULT, 32'd9, 32'd9, 1'b0);
      pre_hi = bus.hi; pre_lo = bus.lo;
      bus.req = 1'b1; bus.op = MDU_MULT; bus.a = 32'd5; bus.b = 32'd6;
      tick();
      bus.op = MDU_MTHI; bus.a = 32'h1234;
      #1;
      chk("mthi_busy_start", 64'(bus.start), 64'd0);
      tick();
      chk("mthi_busy_hi", 64'(bus.hi), 64'(pre_hi));
      bus.op = MDU_MFLO;
      #1;
      chk("rd_busy_lo", 64'(bus.rd_data), 64'(pre_lo));
      bus.op = MDU_MULT; bus.a = 32'd100; bus.b = 32'd100;
      #1;
      chk("start_while_busy", 64'(bus.start), 64'd0);
      tick();
      bus.req = 1'b0; bus.op = MDU_NONE;
      w = 0;
      while (bus.busy && w < 200) begin w++; tick(); end
      chk("busy_drop_timeout", 64'(w < 200), 64'd1);
      chk("busy_mult_hi", 64'(bus.hi), 64'd0);
      chk("busy_mult_lo", 64'(bus.lo), 64'd30);

      // mthi / mtlo / mfhi / mflo when idle
      bus.req = 1'b1; bus.op = MDU_MTHI; bus.a = 32'h1234;
      tick();
      bus.op = MDU_MFHI;
      #1;
      chk("mthi_idle_hi", 64'(bus.hi), 64'h1234);
      chk("mthi_lo_kept", 64'(bus.lo), 64'd30);
      chk("mfhi_rd", 64'(bus.rd_data), 64'h1234);
      bus.op = MDU_MTLO; bus.a = 32'hCAFEF00D;
      tick();
      bus.op = MDU_MFLO;
      #1;
      chk("mflo_rd", 64'(bus.rd_data), 64'hCAFEF00D);
      bus.op = MDU_NONE;
      #1;
      chk("rd_none", 64'(bus.rd_data), 64'd0);
      bus.req = 1'b0;

      // reset at T+3 of a mult aborts it with no late commit
      bus.req = 1'b1; bus.op = MDU_MULT; bus.a = 32'hFFFFFFFD; bus.b = 32'd7;
      tick();
      bus.req = 1'b0; bus.op = MDU_NONE;
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      chk("midrst_hi", 64'(bus.hi), 64'd0);
      chk("midrst_lo", 64'(bus.lo), 64'd0);
      repeat (8) tick();
      chk("midrst_late_hi", 64'(bus.hi), 64'd0);
      chk("midrst_late_lo", 64'(bus.lo), 64'd0);
      run_op("mult_post_rst", MDU_MULTU, 32'd3, 32'd4, 1'b1);
      run_op("mult_b2b", MDU_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);

      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles per mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles per div/divu.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port reset  in  1  synchronous active-high reset.
REQ-006 SHALL have port req  in  1  E-stage instruction is an MDU op this cycle.
REQ-007 SHALL have port op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; others treated as none.
REQ-008 SHALL have port a  in  32  rs operand (forwarded).
REQ-009 SHALL have port b  in  32  rt operand (forwarded).
REQ-010 SHALL have port d_is_mdu  in  1  D-stage instruction is any MDU op.
REQ-011 SHALL have port start  out  1  combinational: req & op in {1..4} & !busy.
REQ-012 SHALL have port busy  out  1  registered: multi-cycle op in progress.
REQ-013 SHALL have port stall  out  1  combinational: d_is_mdu & (busy | start); drives the en/clear of the pipeline registers.
REQ-014 SHALL have port rd_data  out  32  combinational: HI for mfhi, LO for mflo, else 0.
REQ-015 SHALL have ports hi and lo  out  32 each  architectural HI/LO registers.

Function
REQ-016 Start accepted at cycle T SHALL latch operands and the op, and load the down-counter with N (MULT_CYCLES or DIV_CYCLES).
REQ-017 busy SHALL be 1 in cycles T+1..T+N and 0 from T+N+1.
REQ-018 HI/LO SHALL update at the clock edge ending cycle T+N and SHALL NOT update earlier.
REQ-019 mult SHALL produce the signed 64-bit product and multu the unsigned 64-bit product; {HI,LO} SHALL receive the product.
REQ-020 div/divu SHALL set LO = quotient and HI = remainder; quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-021 div/divu with b == 0 SHALL leave HI/LO unchanged while still holding busy for N cycles.
REQ-022 mthi/mtlo SHALL write a to HI/LO at the end of the issuing cycle when !busy.
REQ-023 mthi/mtlo while busy SHALL be ignored.
REQ-024 A start request while busy SHALL be ignored; upstream stall prevents this case.
REQ-025 rd_data during busy SHALL return the pre-operation HI/LO values; stall prevents this read.
REQ-026 The state machine SHALL have states IDLE -> (start) BUSY -> (counter == 1) IDLE; the commit occurs on that BUSY->IDLE edge.
REQ-027 A start in the same cycle busy falls SHALL NOT be possible, since busy is still 1 in cycle T+N; the next start SHALL be accepted at T+N+1 at the earliest.

Reset
REQ-028 On reset, hi, lo and the counter SHALL be 0, busy SHALL be 0, and state SHALL be IDLE.
REQ-029 Reset mid-operation SHALL abort the operation with no HI/LO commit.

Configuration
REQ-030 Macro MDU_DIV_EN: when defined, div/divu SHALL be implemented per REQ-020/021.
REQ-031 When MDU_DIV_EN is undefined, op 3/4 SHALL be treated as none: no start, no busy, HI/LO unchanged, and no divider logic synthesized.

Structure
REQ-032 The op-code constants (MDU_NONE..MDU_MTLO) SHALL live in shared package mdu_pkg, also used by the controller decoder.
REQ-033 The single sub-module SHALL be mdu_div_core, a 32-bit signed/unsigned divider instantiated only under MDU_DIV_EN.
REQ-034 Multiplication SHALL be inline.

Verification
REQ-035 Bench SHALL cover: reset, then mult a=-3 b=7 -> busy 1 for 5 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFEB.
REQ-036 Bench SHALL cover: multu a=0xFFFFFFFF b=2 -> after 5 cycles hi=1 and lo=0xFFFFFFFE.
REQ-037 Bench SHALL cover: div a=-7 b=2 -> busy for 10 cycles, then lo=0xFFFFFFFD and hi=0xFFFFFFFF; div by b=0 -> hi/lo unchanged.
REQ-038 Bench SHALL cover: mult issued with d_is_mdu=1 -> stall=1 in cycles T..T+5 and 0 at T+6; with d_is_mdu=0 -> stall=0 throughout.
REQ-039 Bench SHALL cover: mthi a=0x1234 while busy -> hi unaffected; the same op when idle -> hi=0x1234 next cycle; mfhi -> rd_data=0x1234.
REQ-040 Bench SHALL cover: reset asserted at cycle T+3 of a mult -> busy=0 and hi=lo=0 next cycle, with no late commit.
